// File: rtl/sreg_skid_stage.sv
// Registered valid/ready stage with a 2-entry skid buffer behind the signed 2:1 mux.
// in_ready and out_valid are decoded from state flops only, so no ready path crosses the stage.
module sreg_skid_stage #(
  parameter int DATAWIDTH = 8
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic signed [DATAWIDTH-1:0] in_d,
  input  logic                        in_sel,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [DATAWIDTH-1:0] out_d,
  output logic                        out_sel,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [1:0]                  occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                      state_reg;
  state_t                      state_next;
  logic signed [DATAWIDTH-1:0] main_d_reg;
  logic                        main_sel_reg;
  logic signed [DATAWIDTH-1:0] skid_d_reg;
  logic                        skid_sel_reg;

  logic in_fire;
  logic out_fire;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (in_fire) begin
          load_main_in = 1'b1;
          state_next   = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          load_skid  = 1'b1;
          state_next = FULL;
        end else if (out_fire) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the consumer side can move.
        if (out_fire) begin
          load_main_skid = 1'b1;
          state_next     = ONE;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  always_comb begin
    out_valid = (state_reg != EMPTY);
    in_ready  = (state_reg != FULL);
    occupancy = state_reg;
  end

  // Main reg keeps its last value after a drain; only reset clears it.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      main_d_reg   <= '0;
      main_sel_reg <= 1'b0;
      skid_d_reg   <= '0;
      skid_sel_reg <= 1'b0;
    end else begin
      if (load_main_in) begin
        main_d_reg   <= in_d;
        main_sel_reg <= in_sel;
      end else if (load_main_skid) begin
        main_d_reg   <= skid_d_reg;
        main_sel_reg <= skid_sel_reg;
      end
      if (load_skid) begin
        skid_d_reg   <= in_d;
        skid_sel_reg <= in_sel;
      end
    end
  end

  assign out_d   = main_d_reg;
  assign out_sel = main_sel_reg;

endmodule

// File: tb/tb_sreg_skid_stage.sv
// Directed vector table plus corner sequences and a random scoreboard run for sreg_skid_stage.
module tb_sreg_skid_stage;

  logic              Clk;
  logic              Rst;
  logic signed [7:0] in_d;
  logic              in_sel;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] out_d;
  logic              out_sel;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        occupancy;

  int n_cmp;
  int n_fail;

  sreg_skid_stage #(.DATAWIDTH(8)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_d      (in_d),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_d     (out_d),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic              in_valid;
    logic signed [7:0] in_d;
    logic              in_sel;
    logic              out_ready;
    logic              exp_ov;
    logic signed [7:0] exp_d;
    logic              exp_sel;
    logic              exp_ir;
    logic [1:0]        exp_occ;
  } vec_t;

  typedef struct {
    logic signed [7:0] d;
    logic              sel;
  } beat_t;

  vec_t  vecs[15];
  beat_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic ov, input logic signed [7:0] d,
                             input logic sel, input logic ir, input logic [1:0] occ);
    chk({tag, ".out_valid"}, int'(out_valid), int'(ov));
    chk({tag, ".out_d"},     int'(out_d),     int'(d));
    chk({tag, ".out_sel"},   int'(out_sel),   int'(sel));
    chk({tag, ".in_ready"},  int'(in_ready),  int'(ir));
    chk({tag, ".occupancy"}, int'(occupancy), int'(occ));
  endtask

  task automatic drive(input logic v, input logic signed [7:0] d, input logic s, input logic r);
    in_valid  = v;
    in_d      = d;
    in_sel    = s;
    out_ready = r;
  endtask

  initial begin
    logic              hold;
    logic              stall_prev;
    logic signed [7:0] prev_d;
    logic              prev_sel;
    logic              in_fire;
    logic              out_fire;
    beat_t             b;

    n_cmp  = 0;
    n_fail = 0;

    //           v     d        s     r     ov    exp_d    sel   ir    occ
    vecs[0]  = '{1'b1, 8'sh80, 1'b0, 1'b1, 1'b1, 8'sh80, 1'b0, 1'b1, 2'd1};
    vecs[1]  = '{1'b1, 8'shFF, 1'b1, 1'b1, 1'b1, 8'shFF, 1'b1, 1'b1, 2'd1};
    vecs[2]  = '{1'b1, 8'sh00, 1'b0, 1'b1, 1'b1, 8'sh00, 1'b0, 1'b1, 2'd1};
    vecs[3]  = '{1'b1, 8'sh7F, 1'b1, 1'b1, 1'b1, 8'sh7F, 1'b1, 1'b1, 2'd1};
    vecs[4]  = '{1'b0, 8'sh00, 1'b0, 1'b1, 1'b0, 8'sh7F, 1'b1, 1'b1, 2'd0};
    vecs[5]  = '{1'b1, 8'sh11, 1'b0, 1'b0, 1'b1, 8'sh11, 1'b0, 1'b1, 2'd1};
    vecs[6]  = '{1'b1, 8'sh22, 1'b1, 1'b0, 1'b1, 8'sh11, 1'b0, 1'b0, 2'd2};
    vecs[7]  = '{1'b1, 8'sh33, 1'b0, 1'b0, 1'b1, 8'sh11, 1'b0, 1'b0, 2'd2};
    vecs[8]  = '{1'b1, 8'sh33, 1'b0, 1'b1, 1'b1, 8'sh22, 1'b1, 1'b1, 2'd1};
    vecs[9]  = '{1'b1, 8'sh33, 1'b0, 1'b1, 1'b1, 8'sh33, 1'b0, 1'b1, 2'd1};
    vecs[10] = '{1'b0, 8'sh00, 1'b0, 1'b1, 1'b0, 8'sh33, 1'b0, 1'b1, 2'd0};
    vecs[11] = '{1'b1, 8'sh7F, 1'b0, 1'b0, 1'b1, 8'sh7F, 1'b0, 1'b1, 2'd1};
    vecs[12] = '{1'b1, 8'sh80, 1'b1, 1'b1, 1'b1, 8'sh80, 1'b1, 1'b1, 2'd1};
    vecs[13] = '{1'b0, 8'sh00, 1'b0, 1'b0, 1'b1, 8'sh80, 1'b1, 1'b1, 2'd1};
    vecs[14] = '{1'b0, 8'sh00, 1'b0, 1'b1, 1'b0, 8'sh80, 1'b1, 1'b1, 2'd0};

    // Reset held with a valid beat offered: nothing may be captured.
    Rst = 1'b0;
    drive(1'b1, 8'sh5A, 1'b1, 1'b1);
    repeat (2) @(posedge Clk);
    #1;
    chk_outputs("reset", 1'b0, 8'sh00, 1'b0, 1'b1, 2'd0);
    drive(1'b0, 8'sh00, 1'b0, 1'b1);
    Rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].in_valid, vecs[i].in_d, vecs[i].in_sel, vecs[i].out_ready);
      @(posedge Clk);
      #1;
      chk_outputs($sformatf("vec%0d", i), vecs[i].exp_ov, vecs[i].exp_d, vecs[i].exp_sel,
                  vecs[i].exp_ir, vecs[i].exp_occ);
      $display("vec%0d: in v=%0d d=%0d s=%0d r=%0d -> out v=%0d d=%0d s=%0d ir=%0d occ=%0d",
               i, vecs[i].in_valid, vecs[i].in_d, vecs[i].in_sel, vecs[i].out_ready,
               out_valid, out_d, out_sel, in_ready, occupancy);
    end

    // Mid-operation reset while FULL: outputs clear before any clock edge.
    drive(1'b1, 8'sh55, 1'b0, 1'b0);
    @(posedge Clk);
    #1;
    drive(1'b1, 8'sh66, 1'b1, 1'b0);
    @(posedge Clk);
    #1;
    chk("midrst.full_occ", int'(occupancy), 2);
    drive(1'b0, 8'sh00, 1'b0, 1'b1);
    #2;
    Rst = 1'b0;
    #1;
    chk_outputs("midrst.async", 1'b0, 8'sh00, 1'b0, 1'b1, 2'd0);
    #2;
    Rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge Clk);
      #1;
      chk_outputs($sformatf("midrst.after%0d", i), 1'b0, 8'sh00, 1'b0, 1'b1, 2'd0);
    end
    drive(1'b1, 8'sh44, 1'b1, 1'b0);
    @(posedge Clk);
    #1;
    chk_outputs("midrst.first", 1'b1, 8'sh44, 1'b1, 1'b1, 2'd1);
    $display("midrst: stale beats discarded, first beat after release d=%0d", out_d);
    drive(1'b0, 8'sh00, 1'b0, 1'b1);
    @(posedge Clk);
    #1;
    chk("midrst.drain", int'(out_valid), 0);

    // Random traffic against a FIFO scoreboard; the producer holds a refused beat.
    hold       = 1'b0;
    stall_prev = 1'b0;
    prev_d     = '0;
    prev_sel   = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (!hold) begin
        in_valid = 1'($urandom_range(0, 1));
        in_d     = 8'($urandom);
        in_sel   = 1'($urandom_range(0, 1));
      end
      out_ready = 1'($urandom_range(0, 1));
      @(negedge Clk);
      chk("rnd.occupancy", int'(occupancy), sb.size());
      chk("rnd.out_valid", int'(out_valid), int'(sb.size() != 0));
      chk("rnd.in_ready", int'(in_ready), int'(sb.size() < 2));
      if (stall_prev) begin
        chk("rnd.stable_d", int'(out_d), int'(prev_d));
        chk("rnd.stable_sel", int'(out_sel), int'(prev_sel));
      end
      in_fire  = in_valid & in_ready;
      out_fire = out_valid & out_ready;
      if (out_fire && sb.size() != 0) begin
        b = sb.pop_front();
        chk("rnd.data", int'(out_d), int'(b.d));
        chk("rnd.sel", int'(out_sel), int'(b.sel));
      end
      if (in_fire) begin
        b.d   = in_d;
        b.sel = in_sel;
        sb.push_back(b);
      end
      hold       = in_valid & ~in_fire;
      stall_prev = out_valid & ~out_ready;
      prev_d     = out_d;
      prev_sel   = out_sel;
      @(posedge Clk);
      #1;
    end
    $display("random: 10000 cycles, %0d beats left in flight", sb.size());

    drive(1'b0, 8'sh00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      if (out_valid && sb.size() != 0) begin
        b = sb.pop_front();
        chk("drain.data", int'(out_d), int'(b.d));
        chk("drain.sel", int'(out_sel), int'(b.sel));
      end
      @(posedge Clk);
      #1;
    end
    chk("drain.empty", int'(out_valid), 0);
    chk("drain.sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
